imem_responder: RTL and testbench

Instruction-memory responder for the pipelined RISC-V core: it answers the fetch stage's program-counter address with an instruction word in the same cycle. A valid/ready load port preloads the program one word at a time. A small FSM holds the core idle until loading completes. This block replaces the testbench-driven instruction input on the fetch stage's read side.

---
 rtl/imem_responder.sv | 165 ++++++++++++++++
 tb/tb_imem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder for the pipelined core's fetch stage.
// A valid/ready port preloads the program one word at a time. A three-state
// FSM (IDLE/LOAD/RUN) keeps the core stalled until the load completes. Fetches
// are answered combinationally, and only loaded, aligned, in-range words are exposed.
module imem_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_start_i,
  input  logic                             ld_valid_i,
  input  logic [31:0]                      ld_data_i,
  input  logic                             ld_last_i,
  output logic                             ld_ready_o,
  input  logic [ADDR_WIDTH-1:0]            raddr_i,
  output logic [31:0]                      im_o,
  output logic                             misalign_o,
  output logic                             core_run_o,
  output logic [$clog2(DEPTH_WORDS):0]     load_count_o,
  output logic                             overflow_o
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = IW + 1;
  localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH_WORDS - 1);
  localparam logic [IW-1:0] PTR_ONE  = IW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   wr_ptr_q;
  logic [CW-1:0]   load_count_q;
  logic            overflow_q;
  logic            core_run_q;
  logic            ld_ready_q;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            wr_en_s;
  logic [IW-1:0]   wr_idx_s;
  logic [IW-1:0]   rd_idx_s;
  logic            upper_zero_s;
  logic            in_range_s;
  logic            aligned_s;

  // A word is accepted whenever LOAD holds ready high and the source is valid.
  // A restart in the same cycle redirects that word to slot 0.
  assign wr_en_s  = (state_q == ST_LOAD) && ld_valid_i;
  assign wr_idx_s = load_start_i ? {IW{1'b0}} : wr_ptr_q;

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= {IW{1'b0}};
      load_count_q <= {CW{1'b0}};
      overflow_q   <= 1'b0;
      core_run_q   <= 1'b0;
      ld_ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_start_i) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= {IW{1'b0}};
            load_count_q <= {CW{1'b0}};
            overflow_q   <= 1'b0;
            ld_ready_q   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_start_i) begin
            // Restart: clear pointer/count; a coincident word becomes word 0.
            overflow_q <= 1'b0;
            if (ld_valid_i) begin
              wr_ptr_q     <= PTR_ONE;
              load_count_q <= CNT_ONE;
              if (ld_last_i) begin
                state_q    <= ST_RUN;
                core_run_q <= 1'b1;
                ld_ready_q <= 1'b0;
              end
            end else begin
              wr_ptr_q     <= {IW{1'b0}};
              load_count_q <= {CW{1'b0}};
            end
          end else if (ld_valid_i) begin
            load_count_q <= load_count_q + CNT_ONE;
            if (ld_last_i) begin
              wr_ptr_q   <= wr_ptr_q + PTR_ONE;
              state_q    <= ST_RUN;
              core_run_q <= 1'b1;
              ld_ready_q <= 1'b0;
            end else if (wr_ptr_q == LAST_PTR) begin
              // Memory full: stop here rather than let the pointer wrap.
              state_q    <= ST_RUN;
              core_run_q <= 1'b1;
              ld_ready_q <= 1'b0;
              overflow_q <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
          end
        end
        ST_RUN: begin
          if (load_start_i) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= {IW{1'b0}};
            load_count_q <= {CW{1'b0}};
            overflow_q   <= 1'b0;
            core_run_q   <= 1'b0;
            ld_ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          core_run_q <= 1'b0;
          ld_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Program storage; not reset, stale words are hidden by the count check.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= ld_data_i;
    end
  end

  assign rd_idx_s     = raddr_i[IW+1:2];
  assign upper_zero_s = ((raddr_i >> (IW + 2)) == {ADDR_WIDTH{1'b0}});
  assign in_range_s   = ({1'b0, rd_idx_s} < load_count_q);
  assign aligned_s    = (raddr_i[1:0] == 2'b00);

  // Zero-latency fetch: expose a word only if it is aligned, loaded and in range.
  always_comb begin
    im_o       = NOP_WORD;
    misalign_o = 1'b0;
    if (state_q == ST_RUN) begin
      misalign_o = !aligned_s;
      if (aligned_s && in_range_s && upper_zero_s) begin
        im_o = mem_q[rd_idx_s];
      end else begin
        im_o = NOP_WORD;
      end
    end else begin
      im_o       = NOP_WORD;
      misalign_o = 1'b0;
    end
  end

  assign ld_ready_o   = ld_ready_q;
  assign core_run_o   = core_run_q;
  assign load_count_o = load_count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: a default-depth instance plus a
// 4-word instance driven by the same stimulus for the truncation case.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = 32'h0;
  logic        ld_last = 1'b0;
  logic [31:0] raddr = 32'h0;

  logic        ready0, mis0, run0, ovf0;
  logic [31:0] im0;
  logic [8:0]  cnt0;
  logic        ready1, mis1, run1, ovf1;
  logic [31:0] im1;
  logic [2:0]  cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] im;
    logic        mis;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] im;
    logic        mis;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  imem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(256)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_start_i(load_start), .ld_valid_i(ld_valid),
    .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_ready_o(ready0), .raddr_i(raddr),
    .im_o(im0), .misalign_o(mis0), .core_run_o(run0), .load_count_o(cnt0),
    .overflow_o(ovf0)
  );

  imem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_start_i(load_start), .ld_valid_i(ld_valid),
    .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_ready_o(ready1), .raddr_i(raddr),
    .im_o(im1), .misalign_o(mis1), .core_run_o(run1), .load_count_o(cnt1),
    .overflow_o(ovf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pulse load_start for one edge.
  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  // Present one load word for one edge.
  task automatic send_word(input logic [31:0] d, input logic last);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Scoreboarded fetch on the default-depth instance.
  task automatic fetch0(input string name, input logic [31:0] a,
                        input logic [31:0] e_im, input logic e_mis);
    exp_t e;
    raddr = a;
    exp_q.push_back('{im: e_im, mis: e_mis});
    #1;
    e = exp_q.pop_front();
    chk({name, "_im"}, im0, e.im);
    chk({name, "_mis"}, {31'b0, mis0}, {31'b0, e.mis});
  endtask

  initial begin
    // Reset state, observed while reset is held.
    #3;
    chk("rst_run", {31'b0, run0}, 32'd0);
    chk("rst_ready", {31'b0, ready0}, 32'd0);
    chk("rst_cnt", {23'b0, cnt0}, 32'd0);
    chk("rst_im", im0, NOP);
    chk("rst_mis", {31'b0, mis0}, 32'd0);
    #4 rst_n = 1'b1;

    // Short load with a two-cycle valid gap.
    pulse_start();
    chk("ld_ready_up", {31'b0, ready0}, 32'd1);
    chk("ld_run_low", {31'b0, run0}, 32'd0);
    send_word(32'h00500093, 1'b0);
    chk("cnt_w1", {23'b0, cnt0}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    chk("cnt_gap", {23'b0, cnt0}, 32'd1);
    send_word(32'h00A00113, 1'b0);
    chk("run_before_last", {31'b0, run0}, 32'd0);
    send_word(32'h002081B3, 1'b1);
    chk("run_after_last", {31'b0, run0}, 32'd1);
    chk("cnt_3", {23'b0, cnt0}, 32'd3);
    chk("ready_run", {31'b0, ready0}, 32'd0);
    chk("ovf_short", {31'b0, ovf0}, 32'd0);

    // Fetch vectors (same expectations hold for the 4-word instance).
    vecs[0] = '{addr: 32'h0000_0000, im: 32'h00500093, mis: 1'b0};
    vecs[1] = '{addr: 32'h0000_0004, im: 32'h00A00113, mis: 1'b0};
    vecs[2] = '{addr: 32'h0000_0008, im: 32'h002081B3, mis: 1'b0};
    vecs[3] = '{addr: 32'h0000_000C, im: NOP,          mis: 1'b0};
    vecs[4] = '{addr: 32'h0000_0006, im: NOP,          mis: 1'b1};
    vecs[5] = '{addr: 32'h0000_1000, im: NOP,          mis: 1'b0};
    vecs[6] = '{addr: 32'h0000_0002, im: NOP,          mis: 1'b1};
    vecs[7] = '{addr: 32'h0000_0400, im: NOP,          mis: 1'b0};
    for (int i = 0; i < 8; i++) begin
      fetch0($sformatf("vec%0d", i), vecs[i].addr, vecs[i].im, vecs[i].mis);
      chk($sformatf("vec%0d_im_d4", i), im1, vecs[i].im);
    end

    // Load words are ignored while running.
    send_word(32'hFFFF_FFFF, 1'b0);
    chk("run_ignore_cnt", {23'b0, cnt0}, 32'd3);
    fetch0("run_ignore_w0", 32'h0, 32'h00500093, 1'b0);

    // Reload from RUN.
    raddr = 32'h0;
    pulse_start();
    chk("reload_run_low", {31'b0, run0}, 32'd0);
    chk("reload_im_nop", im0, NOP);
    chk("reload_cnt0", {23'b0, cnt0}, 32'd0);
    send_word(32'hDEADBEEF, 1'b1);
    fetch0("reload_w0", 32'h0, 32'hDEADBEEF, 1'b0);
    fetch0("reload_w1_hidden", 32'h4, NOP, 1'b0);
    chk("reload_ovf", {31'b0, ovf0}, 32'd0);

    // Restart coinciding with an accepted word: that word becomes word 0.
    pulse_start();
    send_word(32'h1111_1111, 1'b0);
    @(negedge clk);
    load_start = 1'b1; ld_valid = 1'b1; ld_data = 32'h2222_2222; ld_last = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b0; ld_valid = 1'b0;
    chk("restart_cnt", {23'b0, cnt0}, 32'd1);
    send_word(32'h3333_3333, 1'b1);
    fetch0("restart_w0", 32'h0, 32'h2222_2222, 1'b0);
    fetch0("restart_w1", 32'h4, 32'h3333_3333, 1'b0);

    // Truncation on the 4-word instance.
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + i, 1'b0);
    chk("ovf_run", {31'b0, run1}, 32'd1);
    chk("ovf_flag", {31'b0, ovf1}, 32'd1);
    chk("ovf_cnt", {29'b0, cnt1}, 32'd4);
    chk("ovf_ready_low", {31'b0, ready1}, 32'd0);
    send_word(32'hBBBB_BBBB, 1'b0);
    chk("ovf_cnt_5th", {29'b0, cnt1}, 32'd4);
    raddr = 32'hC; #1;
    chk("ovf_w3", im1, 32'hA000_0003);
    raddr = 32'h10; #1;
    chk("ovf_oob", im1, NOP);
    chk("deep_cnt5", {23'b0, cnt0}, 32'd5);
    chk("deep_run_low", {31'b0, run0}, 32'd0);

    // Asynchronous reset in the middle of a load.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, ready0}, 32'd0);
    chk("midrst_cnt", {23'b0, cnt0}, 32'd0);
    chk("midrst_run1", {31'b0, run1}, 32'd0);
    chk("midrst_ovf1", {31'b0, ovf1}, 32'd0);
    chk("midrst_im", im1, NOP);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
